// File: rtl/fetch_unit_pkg.sv
// Shared types and constants for the instruction fetch unit and its buffer.
package fetch_unit_pkg;

  typedef enum logic {
    RUN    = 1'b0,
    HALTED = 1'b1
  } fetch_state_e;

  localparam logic [6:0]  OPCODE_SYSTEM = 7'b1110011;
  localparam logic [31:0] INSTR_BYTES   = 32'd4;
  localparam int          FIFO_ENTRY_W  = 64;

endpackage

// File: rtl/fetch_fifo.sv
// Two-entry instruction buffer holding {pc, instr}; clear has priority over push/pop.
module fetch_fifo
  import fetch_unit_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    push,
  input  logic [FIFO_ENTRY_W-1:0] push_data,
  input  logic                    pop,
  input  logic                    clear,
  output logic [FIFO_ENTRY_W-1:0] head,
  output logic [1:0]              count
);

  logic [FIFO_ENTRY_W-1:0] entries [2];
  logic                    wr_ptr;
  logic                    rd_ptr;
  logic                    pop_ok;
  logic                    push_ok;

  assign pop_ok  = pop && (count != 2'd0);
  // A push into a full buffer is only legal when the head leaves in the same cycle.
  assign push_ok = push && ((count != 2'd2) || pop_ok);
  assign head    = entries[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      entries[0] <= '0;
      entries[1] <= '0;
      wr_ptr     <= 1'b0;
      rd_ptr     <= 1'b0;
      count      <= 2'd0;
    end else if (clear) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push_ok) begin
        entries[wr_ptr] <= push_data;
        wr_ptr          <= ~wr_ptr;
      end
      if (pop_ok) begin
        rd_ptr <= ~rd_ptr;
      end
      count <= count + {1'b0, push_ok} - {1'b0, pop_ok};
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch unit: issues sequential fetches to a 1-cycle memory, buffers
// responses in a 2-entry FIFO, and supports redirect and halt on SYSTEM opcodes.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] read_address,
  input  logic [31:0] read_data,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        halted
);

  fetch_state_e            state;
  logic [31:0]             pc;
  logic [31:0]             req_pc_q;
  logic                    req_q;
  logic [1:0]              fifo_count;
  logic [FIFO_ENTRY_W-1:0] head;
  logic                    pop;
  logic                    halt_take;
  logic                    flush;
  logic                    issue;
  logic [2:0]              occupancy;
  logic [31:0]             redirect_target;

  assign read_address    = pc;
  assign instr_valid     = (fifo_count != 2'd0);
  assign {instr_pc, instr} = head;
  assign halted          = (state == HALTED);
  assign pop             = instr_valid && instr_ready;
  assign redirect_target = redirect_pc & 32'hFFFF_FFFC;

  // Redirect outranks halt; both drop buffered words and the in-flight response.
  assign halt_take = (state == RUN) && pop && (instr[6:0] == OPCODE_SYSTEM) && !redirect;
  assign flush     = redirect || halt_take;

  // Buffered plus in-flight words after this cycle's pop must leave room for one more.
  assign occupancy = {1'b0, fifo_count} + {2'b00, req_q} - {2'b00, pop};
  assign issue     = (state == RUN) && (occupancy < 3'(FIFO_DEPTH));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= RUN;
      pc       <= RESET_PC;
      req_q    <= 1'b0;
      req_pc_q <= '0;
    end else if (redirect) begin
      state <= RUN;
      pc    <= redirect_target;
      req_q <= 1'b0;
    end else if (halt_take) begin
      state <= HALTED;
      req_q <= 1'b0;
    end else if (issue) begin
      req_q    <= 1'b1;
      req_pc_q <= pc;
      pc       <= pc + INSTR_BYTES;
    end else begin
      req_q <= 1'b0;
    end
  end

  fetch_fifo u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (req_q),
    .push_data ({req_pc_q, read_data}),
    .pop       (pop),
    .clear     (flush),
    .head      (head),
    .count     (fifo_count)
  );

endmodule
